// File: rtl/trs_arbiter_if.sv
// Bundles the per-channel request handshakes, the shared output handshake and
// the saturation status lines of the truncate-round-saturate arbiter.
interface trs_arbiter_if #(
  parameter int NUM_CH    = 4,
  parameter int IN_WIDTH  = 36,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 16
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]           req_valid;
  logic [NUM_CH-1:0]           req_ready;
  logic [NUM_CH*IN_WIDTH-1:0]  req_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [OUT_WIDTH-1:0]        out_data;
  logic [CH_W-1:0]             out_ch;
  logic                        out_sat;
  logic [NUM_CH-1:0]           sat_clr;
  logic [NUM_CH*CNT_WIDTH-1:0] sat_cnt;

  // Requesting side: accumulators, downstream packer and status reader.
  modport master (
    output req_valid, req_data, out_ready, sat_clr,
    input  req_ready, out_valid, out_data, out_ch, out_sat, sat_cnt
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, out_ready, sat_clr,
    output req_ready, out_valid, out_data, out_ch, out_sat, sat_cnt
  );
endinterface

// File: rtl/trs_arbiter.sv
// Round-robin arbiter sharing one truncate-round-saturate requantizer among
// NUM_CH channels. Stage 1 holds the granted raw sample, stage 2 is the output
// register carrying the requantized value, its channel tag and a saturation
// flag. Per-channel saturating counters record saturation events that leave
// the block.
module trs_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int IN_WIDTH  = 36,
  parameter int OUT_WIDTH = 16,
  parameter int TRUNC     = 18,
  parameter int CNT_WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  trs_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int T_W  = IN_WIDTH - TRUNC;

  localparam logic signed [T_W-1:0] POS_LIM = T_W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [T_W-1:0] NEG_LIM = T_W'(-(1 << (OUT_WIDTH - 1)));

  logic [CH_W-1:0]     last_ch;
  logic [CH_W-1:0]     grant_ch;
  logic [CH_W-1:0]     cand;
  logic                grant_found;

  logic                s1_valid;
  logic [IN_WIDTH-1:0] s1_data;
  logic [CH_W-1:0]     s1_ch;

  logic                out_valid_r;
  logic [OUT_WIDTH-1:0] out_data_r;
  logic [CH_W-1:0]     out_ch_r;
  logic                out_sat_r;

  logic                s2_open;
  logic                s1_open;
  logic                req_fire;
  logic                out_fire;

  logic [T_W-1:0]      trunc_val;
  logic [T_W-1:0]      round_val;
  logic [OUT_WIDTH-1:0] q_data;
  logic                q_sat;
  logic                unused_low;

  logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt;

  // Stage 2 can take a new sample when empty or when its sample leaves now;
  // stage 1 can take one when empty or when it advances into stage 2.
  assign s2_open  = !out_valid_r || bus.out_ready;
  assign s1_open  = !s1_valid || s2_open;
  assign req_fire = !rst && grant_found && s1_open;
  assign out_fire = out_valid_r && bus.out_ready;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last_ch) + k) % NUM_CH);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  assign bus.req_ready = req_fire ? (NUM_CH'(1) << grant_ch) : '0;

  // Requantize: drop TRUNC LSBs, add the round bit with wrap, clamp to OUT_WIDTH.
  assign trunc_val  = s1_data[IN_WIDTH-1:TRUNC];
  assign round_val  = trunc_val + T_W'(s1_data[TRUNC-1]);
  assign unused_low = ^s1_data[TRUNC-2:0];

  always_comb begin
    q_sat  = 1'b0;
    q_data = round_val[OUT_WIDTH-1:0];
    if ($signed(round_val) > POS_LIM) begin
      q_sat  = 1'b1;
      q_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if ($signed(round_val) < NEG_LIM) begin
      q_sat  = 1'b1;
      q_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
  end

  // Stage 1 captures the granted sample and moves the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_ch    <= '0;
      last_ch  <= CH_W'(NUM_CH - 1);
    end else if (req_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= bus.req_data[grant_ch*IN_WIDTH +: IN_WIDTH];
      s1_ch    <= grant_ch;
      last_ch  <= grant_ch;
    end else if (s1_valid && s2_open) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 output register, frozen while the downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      out_sat_r   <= 1'b0;
    end else if (s2_open) begin
      out_valid_r <= s1_valid;
      if (s1_valid) begin
        out_data_r <= q_data;
        out_ch_r   <= s1_ch;
        out_sat_r  <= q_sat;
      end
    end
  end

  // Saturation event counters: clear has priority, count holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.sat_clr[i]) begin
          cnt[i] <= '0;
        end else if (out_fire && out_sat_r && (out_ch_r == CH_W'(i)) && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.sat_cnt   = cnt;

endmodule

// File: tb/tb_trs_arbiter.sv
// Testbench for trs_arbiter: constant vector table, directed multi-cycle
// sequences and randomized traffic, all cross-checked every cycle against a
// behavioural model of the arbiter.
module tb_trs_arbiter;
  localparam int NUM_CH    = 4;
  localparam int IN_WIDTH  = 36;
  localparam int OUT_WIDTH = 16;
  localparam int TRUNC     = 18;
  localparam int CNT_WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  trs_arbiter_if #(.NUM_CH(NUM_CH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
                   .CNT_WIDTH(CNT_WIDTH)) bus ();

  trs_arbiter #(.NUM_CH(NUM_CH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
                .TRUNC(TRUNC), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          ch;
    logic [35:0] din;
    logic [15:0] q;
    bit          s;
  } vec_t;

  vec_t tbl [10];

  int vectors     = 0;
  int miscompares = 0;
  int dut_accepts = 0;

  // Reference model state: two pipeline slots, pointer, counters.
  bit          m_s1_v;
  logic [35:0] m_s1_d;
  int          m_s1_ch;
  bit          m_s2_v;
  logic [15:0] m_s2_q;
  bit          m_s2_s;
  int          m_s2_ch;
  int          m_last;
  int          m_cnt [NUM_CH];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requantization from the arithmetic definition: floor-divide, add the
  // round bit, wrap into 18 bits, then clamp to 16 bits.
  function automatic void requant(input logic [35:0] din, output logic [15:0] q, output bit s);
    longint v, t, r;
    v = longint'({28'd0, din});
    if (din[35]) v = v - (longint'(1) << 36);
    t = v >>> 18;
    r = t + ((v >>> 17) & 1);
    if (r > 131071) r = r - 262144;
    if (r > 32767) begin
      q = 16'h7FFF; s = 1'b1;
    end else if (r < -32768) begin
      q = 16'h8000; s = 1'b1;
    end else begin
      q = r[15:0]; s = 1'b0;
    end
  endfunction

  function automatic logic [35:0] rand_din();
    logic [63:0] r;
    int          tv;
    longint      lo;
    if ($urandom_range(0, 3) == 0) begin
      r = {$urandom, $urandom};
      return r[35:0];
    end
    tv = int'($urandom_range(0, 80000)) - 40000;
    lo = longint'($urandom_range(0, 262143));
    r  = 64'((longint'(tv) <<< 18) | lo);
    return r[35:0];
  endfunction

  task automatic model_reset();
    m_s1_v = 0; m_s1_d = '0; m_s1_ch = 0;
    m_s2_v = 0; m_s2_q = '0; m_s2_s = 0; m_s2_ch = 0;
    m_last = NUM_CH - 1;
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
  endtask

  task automatic set_data(input int ch, input logic [35:0] d);
    bus.req_data[ch*IN_WIDTH +: IN_WIDTH] = d;
  endtask

  // One clock cycle: compare the DUT against the model mid-cycle, advance the
  // model with this cycle's inputs, then step to just after the next edge.
  task automatic applyStimulus();
    bit          s2_open, s1_open;
    int          gch;
    logic [3:0]  exp_ready;
    logic [63:0] exp_cnt;
    @(negedge clk);
    checkOutput("out_valid", 64'(bus.out_valid), 64'(m_s2_v));
    if (m_s2_v) begin
      checkOutput("out_data", 64'(bus.out_data), 64'(m_s2_q));
      checkOutput("out_ch", 64'(bus.out_ch), 64'(m_s2_ch));
      checkOutput("out_sat", 64'(bus.out_sat), 64'(m_s2_s));
    end
    s2_open = !m_s2_v || bus.out_ready;
    s1_open = !m_s1_v || s2_open;
    gch = -1;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (gch < 0 && bus.req_valid[(m_last + k) % NUM_CH]) gch = (m_last + k) % NUM_CH;
    end
    exp_ready = (gch >= 0 && s1_open) ? 4'(1 << gch) : 4'd0;
    checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    exp_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) exp_cnt[i*16 +: 16] = 16'(m_cnt[i]);
    checkOutput("sat_cnt", bus.sat_cnt, exp_cnt);
    if (|(bus.req_valid & bus.req_ready)) dut_accepts++;

    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.sat_clr[i]) m_cnt[i] = 0;
      else if (m_s2_v && bus.out_ready && m_s2_s && m_s2_ch == i && m_cnt[i] < 65535) m_cnt[i]++;
    end
    if (s2_open) begin
      m_s2_v = m_s1_v;
      if (m_s1_v) begin
        requant(m_s1_d, m_s2_q, m_s2_s);
        m_s2_ch = m_s1_ch;
      end
    end
    if (gch >= 0 && s1_open) begin
      m_s1_v = 1; m_s1_d = bus.req_data[gch*IN_WIDTH +: IN_WIDTH]; m_s1_ch = gch; m_last = gch;
    end else if (s2_open) begin
      m_s1_v = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear immediately, without a clock edge.
  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst out_data", 64'(bus.out_data), 64'd0);
    checkOutput("rst out_ch", 64'(bus.out_ch), 64'd0);
    checkOutput("rst out_sat", 64'(bus.out_sat), 64'd0);
    checkOutput("rst req_ready", 64'(bus.req_ready), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    checkOutput("rst sat_cnt", bus.sat_cnt, 64'd0);
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          exp_sat [NUM_CH];
    logic [35:0] d;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    bus.sat_clr   = '0;
    #2;
    doReset();

    // Single-request vectors through an empty pipeline.
    tbl[0] = '{2, 36'h000160000, 16'h0006, 1'b0};
    tbl[1] = '{1, 36'h271000000, 16'h7FFF, 1'b1};
    tbl[2] = '{3, 36'hD8F000000, 16'h8000, 1'b1};
    tbl[3] = '{0, 36'h7FFFE0000, 16'h8000, 1'b1};
    tbl[4] = '{0, 36'h1FFFC0000, 16'h7FFF, 1'b0};
    tbl[5] = '{2, 36'h1FFFE0000, 16'h7FFF, 1'b1};
    tbl[6] = '{3, 36'hE00000000, 16'h8000, 1'b0};
    tbl[7] = '{1, 36'hDFFFC0000, 16'h8000, 1'b1};
    tbl[8] = '{2, 36'hFFFFFFFFF, 16'h0000, 1'b0};
    tbl[9] = '{0, 36'hFFFF60000, 16'hFFFE, 1'b0};
    for (int i = 0; i < NUM_CH; i++) exp_sat[i] = 0;

    for (int v = 0; v < 10; v++) begin
      bus.req_valid = 4'(1 << tbl[v].ch);
      set_data(tbl[v].ch, tbl[v].din);
      applyStimulus();
      bus.req_valid = '0;
      set_data(tbl[v].ch, 36'h123456789);
      checkOutput("tbl early valid", 64'(bus.out_valid), 64'd0);
      applyStimulus();
      checkOutput("tbl out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("tbl out_data", 64'(bus.out_data), 64'(tbl[v].q));
      checkOutput("tbl out_ch", 64'(bus.out_ch), 64'(tbl[v].ch));
      checkOutput("tbl out_sat", 64'(bus.out_sat), 64'(tbl[v].s));
      if (tbl[v].s) exp_sat[tbl[v].ch]++;
    end
    applyStimulus();
    applyStimulus();
    for (int c = 0; c < NUM_CH; c++)
      checkOutput("tbl sat_cnt", 64'(bus.sat_cnt[c*CNT_WIDTH +: CNT_WIDTH]), 64'(exp_sat[c]));

    // Round-robin order with every channel requesting continuously.
    doReset();
    for (int c = 0; c < NUM_CH; c++) begin
      d = 36'(longint'((c + 1) * 1000) <<< 18);
      set_data(c, d);
    end
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    for (int k = 0; k < 12; k++) begin
      checkOutput("rr out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("rr out_ch", 64'(bus.out_ch), 64'(k % NUM_CH));
      checkOutput("rr out_data", 64'(bus.out_data), 64'((k % NUM_CH + 1) * 1000));
      applyStimulus();
    end

    // Sustained backpressure from an empty pipeline.
    doReset();
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b0;
    dut_accepts = 0;
    for (int k = 0; k < 10; k++) applyStimulus();
    checkOutput("stall accepts", 64'(dut_accepts), 64'd2);
    checkOutput("stall req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("stall out_data", 64'(bus.out_data), 64'd1000);
    checkOutput("stall out_ch", 64'(bus.out_ch), 64'd0);
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    applyStimulus();
    checkOutput("release out_ch", 64'(bus.out_ch), 64'd1);
    checkOutput("release out_data", 64'(bus.out_data), 64'd2000);
    applyStimulus();
    checkOutput("release drained", 64'(bus.out_valid), 64'd0);

    // Counter saturation at all-ones, then clear colliding with an increment.
    doReset();
    set_data(0, 36'h271000000);
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 65540; k++) applyStimulus();
    checkOutput("cnt hold max", 64'(bus.sat_cnt[15:0]), 64'hFFFF);
    applyStimulus();
    applyStimulus();
    checkOutput("cnt stays max", 64'(bus.sat_cnt[15:0]), 64'hFFFF);
    checkOutput("clr pre out_sat", 64'(bus.out_sat), 64'd1);
    bus.sat_clr = 4'b0001;
    applyStimulus();
    bus.sat_clr = '0;
    checkOutput("clr beats inc", 64'(bus.sat_cnt[15:0]), 64'd0);
    bus.req_valid = '0;
    for (int k = 0; k < 3; k++) applyStimulus();

    // Reset with both stages full, then first grant after release.
    set_data(2, 36'h000160000);
    bus.req_valid = 4'b0100;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus();
    checkOutput("full before rst", 64'(bus.out_valid), 64'd1);
    doReset();
    bus.req_valid = 4'b1010;
    bus.out_ready = 1'b1;
    set_data(1, 36'h000160000);
    set_data(3, 36'h271000000);
    #1;
    checkOutput("post rst grant", 64'(bus.req_ready), 64'b0010);
    checkOutput("post rst no stale", 64'(bus.out_valid), 64'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("post rst first ch", 64'(bus.out_ch), 64'd1);
    bus.req_valid = '0;
    for (int k = 0; k < 3; k++) applyStimulus();

    // Randomized traffic checked by the model.
    for (int k = 0; k < 3000; k++) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      for (int c = 0; c < NUM_CH; c++) set_data(c, rand_din());
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.sat_clr   = ($urandom_range(0, 19) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
      applyStimulus();
    end
    bus.req_valid = '0;
    bus.sat_clr   = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trs_arbiter.md
Name: trs_arbiter

Overview:
- Shares one truncate-round-saturate requantization datapath among NUM_CH requesting channels.
- Arbitration is round-robin. Each channel uses a valid/ready handshake; the output also uses valid/ready.
- Output is a 2-stage pipeline with channel tag and saturation flag.
- Keeps a per-channel saturation event counter for status readback.
- Sits between per-channel accumulators and the downstream packer.

Parameters:
- NUM_CH, 4: number of requesting channels (2..16).
- IN_WIDTH, 36: input sample width, two's complement.
- OUT_WIDTH, 16: output sample width, two's complement.
- TRUNC, 18: number of LSBs discarded; din[TRUNC-1] is the round bit.
- CNT_WIDTH, 16: width of each saturation counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel grant/accept.
- req_data  in  NUM_CH*IN_WIDTH  channel i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_WIDTH  requantized sample.
- out_ch  out  $clog2(NUM_CH)  channel tag of out_data.
- out_sat  out  1  saturation occurred on out_data.
- sat_clr  in  NUM_CH  synchronous clear of the per-channel counter.
- sat_cnt  out  NUM_CH*CNT_WIDTH  per-channel saturation event counts.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0, out_sat=0.
  - Both pipeline stages empty; all sat_cnt=0.
  - Round-robin pointer set so channel 0 has highest priority.
  - req_ready=0 while rst is high.
- Transfers:
  - A request transfer occurs when req_valid[i] && req_ready[i].
  - An output transfer occurs when out_valid && out_ready.
- Arbitration:
  - Search starts at the channel after the last granted one, wrapping NUM_CH-1 -> 0.
  - The first channel found with req_valid=1 is granted.
  - At most one req_ready bit is high per cycle, and only when stage 1 can accept: stage 1 is empty, or stage 1 advances this cycle.
  - req_ready is combinational from req_valid and pipeline state.
  - The pointer updates only on a transfer.
- Stage 1: registers the granted din and channel index.
- Stage 2 (output register):
  - t = din[IN_WIDTH-1:TRUNC], width IN_WIDTH-TRUNC.
  - r = t + din[TRUNC-1], modulo 2^(IN_WIDTH-TRUNC). No headroom bit: the max positive t plus round wraps negative, by design.
  - If r > 2^(OUT_WIDTH-1)-1: out_data = max positive, out_sat=1.
  - If r < -2^(OUT_WIDTH-1): out_data = min negative, out_sat=1.
  - Otherwise out_data = r[OUT_WIDTH-1:0], out_sat=0.
- Latency and throughput:
  - Request transfer in cycle N gives out_valid in cycle N+2 with no stall.
  - Throughput is 1 sample/cycle.
- Backpressure:
  - Stage 2 holds out_data/out_ch/out_sat stable while out_valid && !out_ready.
  - Stage 1 advances into stage 2 only if stage 2 is empty or transferring.
  - No sample is dropped or duplicated.
  - Sustained stall fills both stages, then req_ready=0 for all channels.
- Saturation counters:
  - sat_cnt[out_ch] increments on an output transfer with out_sat=1, not on stalled cycles.
  - Counters hold at all-ones (no wrap).
  - sat_clr[i] zeroes counter i next cycle. If clear and increment coincide on the same channel, clear wins and the result is 0.
- req_data is sampled only on transfer; a channel may change data freely when not granted.
- Reset mid-operation discards in-flight samples; no output transfer is produced for them.

Test Plan (IN_WIDTH=36, TRUNC=18, OUT_WIDTH=16, NUM_CH=4):
1. Ch2 single request, din=0x000160000, out_ready=1 -> 2 cycles later out_valid=1, out_data=0x0006, out_ch=2, out_sat=0.
2. Ch1 din=0x271000000 (+40000 after trunc), then ch3 din=0xD8F000000 (-40000) -> out_data=0x7FFF then 0x8000, both out_sat=1; sat_cnt[1]=1, sat_cnt[3]=1.
3. All 4 channels continuously valid, out_ready=1 -> grant order 0,1,2,3,0,1,…; one output per cycle after 2-cycle fill; out_ch sequence matches.
4. out_ready held 0 for 10 cycles with all channels valid -> exactly 2 samples accepted, then req_ready=0000; out_data stable. Release out_ready -> samples emerge in order, none lost.
5. Ch0 saturating sample at output with out_ready=1 and sat_clr[0]=1 in the same cycle -> sat_cnt[0]=0. Force counter to 0xFFFF, then another saturation -> stays 0xFFFF.
6. Assert rst with both stages full -> out_valid=0 immediately (async). After release, no stale output appears; the first grant goes to the lowest-index valid channel.
